// File: rtl/udp_dram_recv_mc.sv
// UDP payload to DRAM receiver: parses the header, picks a channel from the
// destination port, streams payload into the data FIFO and issues burst commands.
module udp_dram_recv_mc #(
  parameter int          ADDR_W    = 32,
  parameter int          MAX_BURST = 64,
  parameter int          HDR_WORDS = 4,
  parameter int          NCH       = 2,
  parameter logic [15:0] BASE_PORT = 16'h4000,
  parameter logic [31:0] CH_BASE   = 32'h0000_0000,
  parameter logic [31:0] CH_SPAN   = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_req,
  input  logic              r_enable,
  output logic              r_ack,
  input  logic [31:0]       r_data,
  output logic              w_req,
  output logic              w_enable,
  input  logic              w_ack,
  output logic [31:0]       w_data,
  output logic [35:0]       data_in,
  output logic              data_we,
  output logic [8+ADDR_W-1:0] ctrl_in,
  output logic              ctrl_we,
  input  logic              ctrl_ready,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic [3:0]        dbg_state
);

  // Handshake: a word on r_data is accepted on every cycle r_enable is high;
  // a packet may only begin while r_ack is high. A command is transferred on
  // each cycle with ctrl_we high, which only happens while ctrl_ready is high.

  typedef enum logic [2:0] {
    RX_IDLE, RX_HDR, RX_OFS, RX_DATA, RX_COMMIT, RX_WAIT, RX_DROP
  } rx_t;
  typedef enum logic {C_IDLE, C_ISSUE} ct_t;

  rx_t               r_rx;
  ct_t               r_ct;
  logic [31:0]       r_rd_q;
  logic              r_en_q;
  logic [7:0]        r_hcnt;
  logic [15:0]       r_port;
  logic [15:0]       r_n;
  logic [1:0]        r_lmod;
  logic [31:0]       r_ofs;
  logic [15:0]       r_ch;
  logic [15:0]       r_dcnt;
  logic [15:0]       r_pkt;
  logic [15:0]       r_drop;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_rem;

  logic              w_port_ok;
  logic              w_len_ok;
  logic [3:0]        w_last_strb;
  logic              w_unused;

  assign w_port_ok = ({1'b0, r_port} >= {1'b0, BASE_PORT}) &&
                     ({1'b0, r_port} <  (17'(BASE_PORT) + 17'(NCH)));
  assign w_len_ok  = (r_rd_q[15:0] >= 16'd8);

  always_comb begin
    w_last_strb = 4'hF;
    case (r_lmod)
      2'd1:    w_last_strb = 4'h1;
      2'd2:    w_last_strb = 4'h3;
      2'd3:    w_last_strb = 4'h7;
      default: w_last_strb = 4'hF;
    endcase
  end

  // Receive side: r_en_q qualifies r_rd_q, so a low r_en_q mid-packet means truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx   <= RX_IDLE;
      r_rd_q <= '0;
      r_en_q <= 1'b0;
      r_hcnt <= '0;
      r_port <= '0;
      r_n    <= '0;
      r_lmod <= '0;
      r_ofs  <= '0;
      r_ch   <= '0;
      r_dcnt <= '0;
      r_pkt  <= '0;
      r_drop <= '0;
    end else begin
      r_rd_q <= r_data;
      r_en_q <= r_enable;
      case (r_rx)
        RX_IDLE: begin
          r_hcnt <= '0;
          if (r_enable && r_ack) r_rx <= RX_HDR;
        end
        RX_HDR: begin
          if (!r_en_q) begin
            r_rx   <= RX_DROP;
            r_drop <= r_drop + 16'd1;
          end else begin
            if (r_hcnt == 8'd2) r_port <= r_rd_q[15:0];
            if (r_hcnt == 8'(HDR_WORDS - 1)) begin
              r_n    <= {2'b00, r_rd_q[15:2]} + {15'd0, |r_rd_q[1:0]} - 16'd1;
              r_lmod <= r_rd_q[1:0];
              if (w_port_ok && w_len_ok) begin
                r_rx <= RX_OFS;
              end else begin
                r_rx   <= RX_DROP;
                r_drop <= r_drop + 16'd1;
              end
            end else begin
              r_hcnt <= r_hcnt + 8'd1;
            end
          end
        end
        RX_OFS: begin
          if (!r_en_q) begin
            r_rx   <= RX_DROP;
            r_drop <= r_drop + 16'd1;
          end else begin
            r_ofs  <= r_rd_q;
            r_ch   <= r_port - BASE_PORT;
            r_dcnt <= r_n;
            r_rx   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (!r_en_q) begin
            r_rx   <= RX_DROP;
            r_drop <= r_drop + 16'd1;
          end else if (r_dcnt == 16'd1) begin
            r_rx <= RX_COMMIT;
          end else begin
            r_dcnt <= r_dcnt - 16'd1;
          end
        end
        RX_COMMIT: begin
          r_pkt <= r_pkt + 16'd1;
          r_rx  <= RX_WAIT;
        end
        RX_WAIT: if (!r_enable) r_rx <= RX_IDLE;
        RX_DROP: if (!r_enable) r_rx <= RX_IDLE;
        default: r_rx <= RX_IDLE;
      endcase
    end
  end

  // Command side: one command set outstanding, split into MAX_BURST-word bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ct   <= C_IDLE;
      r_addr <= '0;
      r_rem  <= '0;
    end else begin
      case (r_ct)
        C_IDLE: begin
          if (r_rx == RX_COMMIT) begin
            r_addr <= ADDR_W'(CH_BASE) + ADDR_W'(r_ch) * ADDR_W'(CH_SPAN) +
                      ADDR_W'({r_ofs, 2'b00});
            r_rem  <= r_n;
            r_ct   <= C_ISSUE;
          end
        end
        C_ISSUE: begin
          if (ctrl_ready) begin
            r_addr <= r_addr + ADDR_W'(MAX_BURST * 4);
            r_rem  <= r_rem - 16'(MAX_BURST);
            if (r_rem <= 16'(MAX_BURST)) r_ct <= C_IDLE;
          end
        end
        default: r_ct <= C_IDLE;
      endcase
    end
  end

  assign r_ack     = (r_rx == RX_IDLE) && (r_ct == C_IDLE);
  assign data_we   = (r_rx == RX_DATA) && r_en_q;
  assign data_in   = {(r_dcnt == 16'd1) ? w_last_strb : 4'hF, r_rd_q};
  assign ctrl_we   = (r_ct == C_ISSUE) && ctrl_ready && !rst;
  assign ctrl_in   = {(r_rem > 16'(MAX_BURST)) ? 8'(MAX_BURST) : r_rem[7:0], r_addr};
  assign pkt_cnt   = r_pkt;
  assign drop_cnt  = r_drop;
  assign dbg_state = {r_ct, r_rx};
  assign w_req     = 1'b0;
  assign w_enable  = 1'b0;
  assign w_data    = 32'd0;
  assign w_unused  = r_req ^ w_ack;

endmodule

// File: tb/tb_udp_dram_recv_mc.sv
// Directed and randomized bench for udp_dram_recv_mc with a packet-level
// reference model producing expected FIFO words and burst commands.
module tb_udp_dram_recv_mc;
  localparam int          HDR_WORDS = 4;
  localparam int          NCH       = 2;
  localparam int          MAX_BURST = 64;
  localparam logic [15:0] BASE_PORT = 16'h4000;
  localparam logic [31:0] CH_BASE   = 32'h0000_0000;
  localparam logic [31:0] CH_SPAN   = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_req, r_enable, r_ack;
  logic [31:0] r_data;
  logic        w_req, w_enable, w_ack;
  logic [31:0] w_data;
  logic [35:0] data_in;
  logic        data_we;
  logic [39:0] ctrl_in;
  logic        ctrl_we, ctrl_ready;
  logic [15:0] pkt_cnt, drop_cnt;
  logic [3:0]  dbg_state;

  udp_dram_recv_mc dut (
    .clk(clk), .rst(rst), .r_req(r_req), .r_enable(r_enable), .r_ack(r_ack),
    .r_data(r_data), .w_req(w_req), .w_enable(w_enable), .w_ack(w_ack),
    .w_data(w_data), .data_in(data_in), .data_we(data_we), .ctrl_in(ctrl_in),
    .ctrl_we(ctrl_we), .ctrl_ready(ctrl_ready), .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [35:0] exp_d_q[$];
  logic [39:0] exp_c_q[$];
  int          exp_pkt = 0;
  int          exp_drop = 0;
  int          rdy_mode = 1;  // 0 low, 1 high, 2 random, 3 driven by test

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] last_strb(input int len);
    case (len % 4)
      1: return 4'h1;
      2: return 4'h3;
      3: return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  // Scoreboard: every FIFO write and command must match the model's queues.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (exp_c_q.size() > 0) chk("r_ack_busy", {63'd0, r_ack}, 64'd0);
      if (data_we === 1'b1) begin
        if (exp_d_q.size() > 0) chk("data_in", {28'd0, data_in}, {28'd0, exp_d_q.pop_front()});
        else chk("data_we_extra", {63'd0, data_we}, 64'd0);
      end
      if (ctrl_we === 1'b1) begin
        if (exp_c_q.size() > 0) chk("ctrl_in", {24'd0, ctrl_in}, {24'd0, exp_c_q.pop_front()});
        else chk("ctrl_we_extra", {63'd0, ctrl_we}, 64'd0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ctrl_ready = 1'b0;
        1: ctrl_ready = 1'b1;
        2: ctrl_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Builds a packet, queues the expected outcome and streams it one word per cycle.
  task automatic send_pkt(input int port, input int len, input logic [31:0] ofs,
                          input int trunc);
    logic [31:0] pw[$];
    logic [31:0] w;
    logic [31:0] a;
    int nwords, n, nd, rem, blen, t;
    bit ok;
    for (int i = 0; i < HDR_WORDS; i++) begin
      w = $urandom;
      if (i == 2) w[15:0] = 16'(port);
      if (i == HDR_WORDS - 1) w[15:0] = 16'(len);
      pw.push_back(w);
    end
    nwords = (len + 3) / 4;
    n = nwords - 1;
    ok = (port >= int'(BASE_PORT)) && (port < int'(BASE_PORT) + NCH) && (len >= 8);
    nd = (trunc < 0) ? n : trunc;
    if (nwords > 0) pw.push_back(ofs);
    for (int i = 0; i < nd; i++) begin
      w = $urandom;
      pw.push_back(w);
      if (ok) exp_d_q.push_back({(i == n - 1) ? last_strb(len) : 4'hF, w});
    end
    t = 0;
    while (r_ack !== 1'b1 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) chk("r_ack_timeout", {63'd0, r_ack}, 64'd1);
    r_req = 1'b1;
    foreach (pw[i]) begin
      r_enable = 1'b1;
      r_data = pw[i];
      @(posedge clk);
      #1;
    end
    r_enable = 1'b0;
    r_req = 1'b0;
    if (ok && trunc < 0) begin
      exp_pkt++;
      a = CH_BASE + 32'(port - int'(BASE_PORT)) * CH_SPAN + (ofs << 2);
      rem = n;
      while (rem > 0) begin
        blen = (rem > MAX_BURST) ? MAX_BURST : rem;
        exp_c_q.push_back({8'(blen), a});
        a = a + 32'(MAX_BURST * 4);
        rem = rem - blen;
      end
    end else begin
      exp_drop++;
    end
  endtask

  task automatic settle_and_check(input string tag);
    int t;
    t = 0;
    while ((r_ack !== 1'b1 || exp_c_q.size() > 0) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) chk({tag, "_idle_timeout"}, {63'd0, r_ack}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_pkt_cnt"}, {48'd0, pkt_cnt}, 64'(exp_pkt));
    chk({tag, "_drop_cnt"}, {48'd0, drop_cnt}, 64'(exp_drop));
    chk({tag, "_data_left"}, 64'(exp_d_q.size()), 64'd0);
    chk({tag, "_cmd_left"}, 64'(exp_c_q.size()), 64'd0);
  endtask

  initial begin
    int t, port, len;
    rst = 1'b1; r_req = 1'b0; r_enable = 1'b0; r_data = '0; w_ack = 1'b0;
    ctrl_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_r_ack", {63'd0, r_ack}, 64'd1);
    chk("rst_data_we", {63'd0, data_we}, 64'd0);
    chk("rst_ctrl_we", {63'd0, ctrl_we}, 64'd0);
    chk("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
    chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("tied_w", {31'd0, w_req, w_enable, w_data}, 64'd0);

    // Short packet on channel 0
    send_pkt(int'(BASE_PORT), 16, 32'h10, -1);
    settle_and_check("t1");

    // Long packet on channel 1 splitting into three bursts
    send_pkt(int'(BASE_PORT) + 1, 522, 32'h0, -1);
    settle_and_check("t2");

    // Same with ctrl_ready held low for 5 cycles after the first command
    rdy_mode = 3;
    ctrl_ready = 1'b1;
    send_pkt(int'(BASE_PORT) + 1, 522, 32'h0, -1);
    t = 0;
    while (ctrl_we !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("t3_first_cmd_timeout", {63'd0, ctrl_we}, 64'd1);
    @(posedge clk);
    #1 ctrl_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_ctrl_we_held", {63'd0, ctrl_we}, 64'd0);
      chk("t3_r_ack_held", {63'd0, r_ack}, 64'd0);
    end
    @(posedge clk);
    #1 ctrl_ready = 1'b1;
    rdy_mode = 1;
    settle_and_check("t3");

    // Foreign port and too-short length
    send_pkt(int'(BASE_PORT) + 2, 16, 32'h5, -1);
    send_pkt(int'(BASE_PORT), 4, 32'h5, -1);
    settle_and_check("t4");

    // Truncated after 2 of 5 data words
    send_pkt(int'(BASE_PORT), 24, 32'h20, 2);
    settle_and_check("t5");

    // Randomized packets with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 10; k++) begin
      port = int'(BASE_PORT) + int'($urandom_range(0, NCH - 1));
      len = int'($urandom_range(8, 400));
      if ($urandom_range(0, 4) == 0) port = int'(BASE_PORT) + NCH + int'($urandom_range(0, 3));
      if ($urandom_range(0, 6) == 0) len = int'($urandom_range(0, 7));
      send_pkt(port, len, $urandom, -1);
    end
    settle_and_check("rand");
    rdy_mode = 1;

    // Reset while commands are stalled
    rdy_mode = 0;
    send_pkt(int'(BASE_PORT) + 1, 522, 32'h40, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_stalled_r_ack", {63'd0, r_ack}, 64'd0);
    rst = 1'b1;
    rdy_mode = 3;
    exp_c_q.delete();
    exp_d_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    ctrl_ready = 1'b1;
    chk("t6_ctrl_we", {63'd0, ctrl_we}, 64'd0);
    chk("t6_r_ack", {63'd0, r_ack}, 64'd1);
    chk("t6_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
    chk("t6_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    exp_pkt = 0;
    exp_drop = 0;
    rdy_mode = 1;
    send_pkt(int'(BASE_PORT), 40, 32'h7, -1);
    settle_and_check("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
